// File: rtl/vga_pkg.sv
// ------------------------------------------------------------------
// vga_pkg: shared timing types, 640x480@60 defaults, config checks
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package vga_pkg;

  localparam int VGA_CNT_W = 12;

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;

  localparam logic [VGA_CNT_W-1:0] CNT_ONE = {{(VGA_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [VGA_CNT_W:0]   TOT_ONE = {{VGA_CNT_W{1'b0}}, 1'b1};
  localparam logic [VGA_CNT_W+1:0] TOT_MAX = {2'b01, {VGA_CNT_W{1'b0}}};

  typedef struct packed {
    logic [VGA_CNT_W-1:0] display;
    logic [VGA_CNT_W-1:0] fp;
    logic [VGA_CNT_W-1:0] sync;
    logic [VGA_CNT_W-1:0] bp;
  } timing_t;

  function automatic logic [VGA_CNT_W:0] timing_total(input timing_t t);
    return {1'b0, t.display} + {1'b0, t.fp} + {1'b0, t.sync} + {1'b0, t.bp};
  endfunction

  // Summed two bits wider so that oversized fields cannot wrap into a legal total.
  function automatic logic timing_valid(input timing_t t);
    logic [VGA_CNT_W+1:0] sum;
    sum = {2'b00, t.display} + {2'b00, t.fp} + {2'b00, t.sync} + {2'b00, t.bp};
    return (t.display != '0) && (t.fp != '0) && (t.sync != '0) && (t.bp != '0)
           && (sum <= TOT_MAX);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_axis_counter.sv
// ------------------------------------------------------------------
// vga_axis_counter: one raster axis - position counter, wrap, active/sync decode
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module vga_axis_counter
  import vga_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 adv_i,
  input  timing_t              cfg_i,
  output logic [VGA_CNT_W-1:0] count_o,
  output logic                 wrap_o,
  output logic                 active_o,
  output logic                 sync_o
);

  logic [VGA_CNT_W-1:0] count_q, count_d;
  logic [VGA_CNT_W:0]   tot, cnt_x, sync_lo, sync_hi;

  always_comb begin
    tot      = timing_total(cfg_i);
    cnt_x    = {1'b0, count_q};
    sync_lo  = {1'b0, cfg_i.display} + {1'b0, cfg_i.fp};
    sync_hi  = sync_lo + {1'b0, cfg_i.sync};
    wrap_o   = ((cnt_x + TOT_ONE) == tot);
    active_o = (count_q < cfg_i.display);
    sync_o   = (cnt_x >= sync_lo) && (cnt_x < sync_hi);
  end

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (adv_i) begin
      count_d = wrap_o ? '0 : count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ------------------------------------------------------------------
// vga_timing_gen: runtime-reconfigurable VGA/DVI raster timing generator
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CNT_W     = VGA_CNT_W,  // must equal vga_pkg::VGA_CNT_W
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_ce,
  input  logic               en,
  input  logic [4*CNT_W-1:0] cfg_h,
  input  logic [4*CNT_W-1:0] cfg_v,
  input  logic               cfg_load,
  output logic               cfg_pending,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   h_count,
  output logic [CNT_W-1:0]   v_count,
  output logic               h_sync,
  output logic               v_sync,
  output logic               de,
  output logic               line_start,
  output logic               frame_start
);

  localparam timing_t RST_H = '{display: VGA_CNT_W'(H_DISPLAY), fp: VGA_CNT_W'(H_FP),
                                sync: VGA_CNT_W'(H_SYNC), bp: VGA_CNT_W'(H_BP)};
  localparam timing_t RST_V = '{display: VGA_CNT_W'(V_DISPLAY), fp: VGA_CNT_W'(V_FP),
                                sync: VGA_CNT_W'(V_SYNC), bp: VGA_CNT_W'(V_BP)};

  timing_t act_h_q, act_h_d, act_v_q, act_v_d;
  timing_t shd_h_q, shd_h_d, shd_v_q, shd_v_d;
  logic    pend_q, pend_d, err_q, err_d;
  timing_t new_h, new_v;
  logic    load_ok, adv, frame_wrap;

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic h_wrap, v_wrap, h_act, v_act, h_sact, v_sact;

  logic de_q, de_d, hs_q, hs_d, vs_q, vs_d, ls_q, ls_d, fs_q, fs_d;

  assign new_h      = cfg_h;
  assign new_v      = cfg_v;
  assign load_ok    = cfg_load && timing_valid(new_h) && timing_valid(new_v);
  assign adv        = en && pix_ce;
  assign frame_wrap = adv && h_wrap && v_wrap;

  vga_axis_counter u_h (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (!en),
    .adv_i    (adv),
    .cfg_i    (act_h_q),
    .count_o  (h_cnt),
    .wrap_o   (h_wrap),
    .active_o (h_act),
    .sync_o   (h_sact)
  );

  vga_axis_counter u_v (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (!en),
    .adv_i    (adv && h_wrap),
    .cfg_i    (act_v_q),
    .count_o  (v_cnt),
    .wrap_o   (v_wrap),
    .active_o (v_act),
    .sync_o   (v_sact)
  );

  // A stopped raster sits at (0,0), so it counts as a frame boundary for pending config.
  always_comb begin
    act_h_d = act_h_q;
    act_v_d = act_v_q;
    shd_h_d = shd_h_q;
    shd_v_d = shd_v_q;
    pend_d  = pend_q;
    err_d   = err_q;
    if (pend_q && (!en || frame_wrap)) begin
      act_h_d = shd_h_q;
      act_v_d = shd_v_q;
      pend_d  = 1'b0;
    end
    if (cfg_load) begin
      err_d = !load_ok;
      if (load_ok) begin
        if (en) begin
          shd_h_d = new_h;
          shd_v_d = new_v;
          pend_d  = 1'b1;
        end else begin
          act_h_d = new_h;
          act_v_d = new_v;
        end
      end
    end
  end

  always_comb begin
    de_d = de_q;
    hs_d = hs_q;
    vs_d = vs_q;
    ls_d = 1'b0;
    fs_d = 1'b0;
    if (!en) begin
      de_d = 1'b0;
      hs_d = ~HS_POL;
      vs_d = ~VS_POL;
    end else if (pix_ce) begin
      de_d = h_act && v_act;
      hs_d = h_sact ^ ~HS_POL;
      vs_d = v_sact ^ ~VS_POL;
      ls_d = (h_cnt == '0);
      fs_d = (h_cnt == '0) && (v_cnt == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_h_q <= RST_H;
      act_v_q <= RST_V;
      shd_h_q <= RST_H;
      shd_v_q <= RST_V;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      de_q    <= 1'b0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      act_h_q <= act_h_d;
      act_v_q <= act_v_d;
      shd_h_q <= shd_h_d;
      shd_v_q <= shd_v_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  assign cfg_pending = pend_q;
  assign cfg_err     = err_q;
  assign h_count     = h_cnt;
  assign v_count     = v_cnt;
  assign de          = de_q;
  assign h_sync      = hs_q;
  assign v_sync      = vs_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ------------------------------------------------------------------
// tb_vga_timing_gen: directed scoreboard bench for vga_timing_gen (HS_POL=1 build)
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_vga_timing_gen;

  localparam int S_H = 0, S_V = 1, S_DE = 2, S_HS = 3, S_VS = 4;
  localparam int S_LS = 5, S_FS = 6, S_PEND = 7, S_ERR = 8;

  logic        clk = 1'b0;
  logic        rst, pix_ce, en, cfg_load;
  logic [47:0] cfg_h, cfg_v;
  logic        cfg_pending, cfg_err, h_sync, v_sync, de, line_start, frame_start;
  logic [11:0] h_count, v_count;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  event sample_ev;

  vga_timing_gen #(.CNT_W(12), .HS_POL(1'b1), .VS_POL(1'b0)) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_ce      (pix_ce),
    .en          (en),
    .cfg_h       (cfg_h),
    .cfg_v       (cfg_v),
    .cfg_load    (cfg_load),
    .cfg_pending (cfg_pending),
    .cfg_err     (cfg_err),
    .h_count     (h_count),
    .v_count     (v_count),
    .h_sync      (h_sync),
    .v_sync      (v_sync),
    .de          (de),
    .line_start  (line_start),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] mk(input int d, input int f, input int s, input int b);
    return {d[11:0], f[11:0], s[11:0], b[11:0]};
  endfunction

  function automatic logic [31:0] probe(input int sel);
    case (sel)
      S_H:     return {20'd0, h_count};
      S_V:     return {20'd0, v_count};
      S_DE:    return {31'd0, de};
      S_HS:    return {31'd0, h_sync};
      S_VS:    return {31'd0, v_sync};
      S_LS:    return {31'd0, line_start};
      S_FS:    return {31'd0, frame_start};
      S_PEND:  return {31'd0, cfg_pending};
      S_ERR:   return {31'd0, cfg_err};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic push(input int sel, input int exp, input string name);
    chk_t c;
    c.sel  = sel;
    c.exp  = exp;
    c.name = name;
    sb.push_back(c);
  endtask

  task automatic st(input string tag, input int h, input int v, input int d,
                    input int hs, input int vs, input int ls, input int fs);
    push(S_H, h, {tag, ".h_count"});
    push(S_V, v, {tag, ".v_count"});
    push(S_DE, d, {tag, ".de"});
    push(S_HS, hs, {tag, ".h_sync"});
    push(S_VS, vs, {tag, ".v_sync"});
    push(S_LS, ls, {tag, ".line_start"});
    push(S_FS, fs, {tag, ".frame_start"});
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [47:0] h, input logic [47:0] v);
    cfg_h    = h;
    cfg_v    = v;
    cfg_load = 1'b1;
    tick(1);
    cfg_load = 1'b0;
  endtask

  task automatic qstep();
    pix_ce = 1'b1;
    tick(1);
    pix_ce = 1'b0;
  endtask

  task automatic qrun(input int n);
    repeat (n) begin
      qstep();
      tick(3);
    end
  endtask

  // Monitor: compares every queued expectation at the next sample point.
  initial begin
    chk_t        c;
    logic [31:0] act;
    forever begin
      @(negedge clk or sample_ev);
      while (sb.size() > 0) begin
        c   = sb.pop_front();
        act = probe(c.sel);
        n_chk++;
        if (act !== c.exp) begin
          n_fail++;
          $display("FAIL %s: got %0d, want %0d", c.name, act, c.exp);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [47:0] def_h, def_v, a_h, a_v, b_h, b_v, c_h, c_v;
    def_h = mk(640, 16, 96, 48);
    def_v = mk(480, 10, 2, 33);
    a_h   = mk(4, 1, 2, 1);   // 8 per line
    a_v   = mk(3, 1, 1, 1);   // 6 lines
    b_h   = mk(6, 1, 1, 2);   // 10 per line
    b_v   = mk(2, 1, 1, 1);   // 5 lines
    c_h   = mk(3, 1, 1, 1);   // 6 per line
    c_v   = mk(2, 1, 1, 1);   // 5 lines

    rst = 1'b1; en = 1'b0; pix_ce = 1'b0; cfg_load = 1'b0;
    cfg_h = def_h; cfg_v = def_v;
    tick(3);
    st("reset", 0, 0, 0, 0, 1, 0, 0);
    push(S_PEND, 0, "reset.pending");
    push(S_ERR, 0, "reset.err");

    // Default timing, full pixel rate
    rst = 1'b0; en = 1'b1; pix_ce = 1'b1;
    tick(1);   st("def.k1", 1, 0, 1, 0, 1, 1, 1);
    tick(1);   st("def.k2", 2, 0, 1, 0, 1, 0, 0);
    tick(638); push(S_DE, 1, "def.k640.de");
    tick(1);   push(S_DE, 0, "def.k641.de");
    tick(15);  push(S_HS, 0, "def.k656.hs");
    tick(1);   push(S_HS, 1, "def.k657.hs");
    tick(95);  push(S_HS, 1, "def.k752.hs");
    tick(1);   push(S_HS, 0, "def.k753.hs");
    tick(47);  st("def.k800", 0, 1, 0, 0, 1, 0, 0);
    tick(1);   st("def.k801", 1, 1, 1, 0, 1, 1, 0);
    tick(299); st("def.k1100", 300, 1, 1, 0, 1, 0, 0);

    // en dropped mid-frame
    en = 1'b0;
    tick(1);   st("endrop", 0, 0, 0, 0, 1, 0, 0);

    // Invalid loads: zero sync width, then total 4097
    load(mk(640, 16, 0, 48), def_v);
    push(S_ERR, 1, "bad_sync.err");
    push(S_PEND, 0, "bad_sync.pending");
    en = 1'b1;
    tick(1);   st("reen.k1", 1, 0, 1, 0, 1, 1, 1);
    load(mk(4000, 32, 32, 33), def_v);
    push(S_ERR, 1, "bad_tot.err");
    push(S_PEND, 0, "bad_tot.pending");
    push(S_H, 2, "bad_tot.h_count");
    tick(655); push(S_HS, 1, "keep.k657.hs");
    tick(143); push(S_H, 0, "keep.k800.h");
    push(S_V, 1, "keep.k800.v");

    // Valid load while stopped is applied at once
    en = 1'b0;
    tick(1);
    load(a_h, a_v);
    push(S_ERR, 0, "loadA.err");
    push(S_PEND, 0, "loadA.pending");

    // Quarter-rate pixel enable on config A
    en = 1'b1;
    qstep();   st("q.s1", 1, 0, 1, 0, 1, 1, 1);
    tick(1);   st("q.s1hold", 1, 0, 1, 0, 1, 0, 0);
    tick(2);
    qrun(4);
    qstep();   st("q.s6", 6, 0, 0, 1, 1, 0, 0);
    tick(1);   st("q.s6hold", 6, 0, 0, 1, 1, 0, 0);
    tick(2);
    qrun(2);
    qstep();   st("q.s9", 1, 1, 1, 0, 1, 1, 0);
    tick(3);
    qrun(23);
    qstep();   st("q.s33", 1, 4, 0, 0, 0, 1, 0);
    tick(3);
    qrun(14);
    qstep();   push(S_H, 0, "q.s48.h"); push(S_V, 0, "q.s48.v");
    tick(3);
    qstep();   push(S_FS, 1, "q.s49.fs"); push(S_LS, 1, "q.s49.ls");
    tick(1);   push(S_FS, 0, "q.s49hold.fs");
    tick(2);

    // Pending config applied at frame boundary (A running, position 1)
    pix_ce = 1'b1;
    load(b_h, b_v);
    push(S_PEND, 1, "loadB.t1.pending");
    push(S_ERR, 0, "loadB.t1.err");
    tick(45);  push(S_H, 7, "A.t46.h"); push(S_V, 5, "A.t46.v");
    push(S_PEND, 1, "A.t46.pending");
    tick(1);   push(S_H, 0, "B.t47.h"); push(S_V, 0, "B.t47.v");
    push(S_PEND, 0, "B.t47.pending");
    tick(1);   st("B.t48", 1, 0, 1, 0, 1, 1, 1);
    tick(5);   push(S_DE, 1, "B.t53.de");
    tick(1);   push(S_DE, 0, "B.t54.de");
    tick(1);   push(S_HS, 1, "B.t55.hs");
    tick(1);   push(S_HS, 0, "B.t56.hs");
    tick(1);   push(S_H, 0, "B.t57.h"); push(S_V, 1, "B.t57.v");
    tick(2);
    load(c_h, c_v);
    push(S_PEND, 1, "loadC.pending");
    tick(36);
    load(a_h, a_v);   // coincides with the B frame wrap
    push(S_H, 0, "C.t97.h"); push(S_V, 0, "C.t97.v");
    push(S_PEND, 1, "C.t97.pending");
    push(S_ERR, 0, "C.t97.err");
    tick(6);   push(S_H, 0, "C.t103.h"); push(S_V, 1, "C.t103.v");
    tick(23);  push(S_PEND, 1, "C.t126.pending");
    push(S_H, 5, "C.t126.h"); push(S_V, 4, "C.t126.v");
    tick(1);   push(S_PEND, 0, "A2.t127.pending");
    push(S_H, 0, "A2.t127.h"); push(S_V, 0, "A2.t127.v");
    tick(8);   push(S_H, 0, "A2.t135.h"); push(S_V, 1, "A2.t135.v");

    // Asynchronous reset mid-line with an 800x600 config pending
    load(mk(800, 40, 128, 88), mk(600, 1, 4, 23));
    push(S_PEND, 1, "svga.pending");
    push(S_ERR, 0, "svga.err");
    tick(5);   push(S_HS, 1, "prerst.hs");
    ->sample_ev;
    #1;
    rst = 1'b1;
    #1;
    st("asyncrst", 0, 0, 0, 0, 1, 0, 0);
    push(S_PEND, 0, "asyncrst.pending");
    ->sample_ev;
    tick(2);
    rst = 1'b0;
    tick(1);   st("post.k1", 1, 0, 1, 0, 1, 1, 1);
    push(S_PEND, 0, "post.k1.pending");
    tick(656); push(S_HS, 1, "post.k657.hs");
    tick(143); push(S_H, 0, "post.k800.h"); push(S_V, 1, "post.k800.v");
    push(S_PEND, 0, "post.k800.pending");

    tick(2);
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
